// File: rtl/rv32i_pkg.sv
// RV32I decode constants and helpers shared by the ID/issue stage.
// Opcode values, instruction field layout, immediate-format selection.
package rv32i_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    imm_fmt_e fmt;
    fmt = FMT_NONE;
    case (opc)
      OP_IMM, LOAD, JALR: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH:             fmt = FMT_B;
      LUI, AUIPC:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      default:            fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic opc_legal(input logic [6:0] opc);
    return opc inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};
  endfunction

endpackage

// File: rtl/id_issue_stage_if.sv
// ID/EX issue bundle: master is the issue stage, slave is the EX stage.
interface id_issue_stage_if;
  import rv32i_pkg::*;

  logic              issue_valid;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [6:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic              wr_reg_n;
  logic              illegal;

  modport master (
    output issue_valid, pc, pc4, data1, data2, funct7, funct3,
           rd, opcode, imm, wr_reg_n, illegal
  );

  modport slave (
    input issue_valid, pc, pc4, data1, data2, funct7, funct3,
          rd, opcode, imm, wr_reg_n, illegal
  );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator for I/S/B/U/J formats.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm
);

  logic signed [DATA_W-1:0] imm_s;

  always_comb begin
    imm_s = '0;
    case (imm_fmt(instr[6:0]))
      FMT_I:   imm_s = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm_s = {instr[31:12], 12'h000};
      FMT_J:   imm_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_s = '0;
    endcase
  end

  assign imm = imm_s;

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage with a per-register pending-write scoreboard (RAW stalls, no forwarding).
// Optional macro ID_WB_BYPASS_EN: a source whose last writer is in WB this cycle is taken from wb_data.
module id_issue_stage
  import rv32i_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instr,
  output logic              id_ready,
  input  logic              flush,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  id_issue_stage_if.master  iss,
  input  logic              wb_wr_reg_n,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_kill,
  input  logic [4:0]        ex_kill_rd
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic              held_valid_q, held_valid_d;
  logic [DATA_W-1:0] held_pc_q, held_pc_d;
  logic [DATA_W-1:0] held_instr_q, held_instr_d;
  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];

  instr_fields_t     f;
  logic [DATA_W-1:0] imm_w;
  logic              legal, rs1_used, rs2_used, writes;
  logic              wb_hit1, wb_hit2;
  logic              rs1_ready, rs2_ready, wr_full;
  logic              stall, issue;
  logic [DATA_W-1:0] data1_v, data2_v;
  logic              sb_ok;

  // Counter update: all same-cycle events add up; wraps only on illegal use (caught by sb_ok).
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic dec_a,
                                                  input logic dec_b);
    return cnt + PEND_W'(inc) - PEND_W'(dec_a) - PEND_W'(dec_b);
  endfunction

  function automatic logic pend_ok(input logic [PEND_W-1:0] cnt, input logic inc,
                                   input logic dec_a, input logic dec_b);
    int sum;
    sum = int'(cnt) + int'(inc) - int'(dec_a) - int'(dec_b);
    return (sum >= 0) && (sum <= int'(PEND_MAX));
  endfunction

  assign f = held_instr_q;

  rv32i_imm_gen u_imm_gen (
    .instr (held_instr_q),
    .imm   (imm_w)
  );

  always_comb begin
    legal    = opc_legal(f.opcode);
    rs1_used = legal && !(f.opcode inside {LUI, AUIPC, JAL});
    rs2_used = f.opcode inside {OP, STORE, BRANCH};
    writes   = (f.opcode inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR}) && (f.rd != 5'd0);
  end

`ifdef ID_WB_BYPASS_EN
  assign wb_hit1 = !wb_wr_reg_n && (wb_rd == f.rs1) && (f.rs1 != 5'd0);
  assign wb_hit2 = !wb_wr_reg_n && (wb_rd == f.rs2) && (f.rs2 != 5'd0);
  assign data1_v = wb_hit1 ? wb_data : rs1_data;
  assign data2_v = wb_hit2 ? wb_data : rs2_data;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign wb_hit1 = 1'b0;
  assign wb_hit2 = 1'b0;
  assign data1_v = rs1_data;
  assign data2_v = rs2_data;
`endif

  // A source is ready once its last pending writer is retiring (bypass) or none remain.
  always_comb begin
    rs1_ready = !rs1_used || (f.rs1 == 5'd0) || (pend_q[f.rs1] == '0) ||
                (wb_hit1 && (pend_q[f.rs1] == PEND_ONE));
    rs2_ready = !rs2_used || (f.rs2 == 5'd0) || (pend_q[f.rs2] == '0) ||
                (wb_hit2 && (pend_q[f.rs2] == PEND_ONE));
    wr_full   = writes && (pend_q[f.rd] == PEND_MAX);
    stall     = held_valid_q && (!rs1_ready || !rs2_ready || wr_full);
    issue     = held_valid_q && !stall && !flush;
    id_ready  = !held_valid_q || issue || flush;
  end

  always_comb begin
    held_valid_d = held_valid_q;
    held_pc_d    = held_pc_q;
    held_instr_d = held_instr_q;
    if (if_valid && id_ready) begin
      held_valid_d = 1'b1;
      held_pc_d    = if_pc;
      held_instr_d = if_instr;
    end else if (issue || flush) begin
      held_valid_d = 1'b0;
    end
  end

  always_comb begin
    sb_ok     = 1'b1;
    pend_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      pend_d[r] = pend_next(pend_q[r], issue && writes && (f.rd == 5'(r)),
                            !wb_wr_reg_n && (wb_rd == 5'(r)),
                            ex_kill && (ex_kill_rd == 5'(r)));
      sb_ok     = sb_ok && pend_ok(pend_q[r], issue && writes && (f.rd == 5'(r)),
                                   !wb_wr_reg_n && (wb_rd == 5'(r)),
                                   ex_kill && (ex_kill_rd == 5'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid_q <= 1'b0;
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
    end
  end

  // Holding register payload is qualified by held_valid_q and needs no reset.
  always_ff @(posedge clk) begin
    held_pc_q    <= held_pc_d;
    held_instr_q <= held_instr_d;
  end

  sb_range_a: assert property (@(posedge clk) disable iff (rst) sb_ok);

  assign rs1_addr        = f.rs1;
  assign rs2_addr        = f.rs2;
  assign iss.issue_valid = issue;
  assign iss.pc          = held_pc_q;
  assign iss.pc4         = held_pc_q + 32'd4;
  assign iss.data1       = data1_v;
  assign iss.data2       = data2_v;
  assign iss.funct7      = f.funct7;
  assign iss.funct3      = f.funct3;
  assign iss.rd          = f.rd;
  assign iss.opcode      = f.opcode;
  assign iss.imm         = imm_w;
  assign iss.wr_reg_n    = !(issue && writes);
  assign iss.illegal     = held_valid_q && !legal;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: vector table plus hazard/flush/kill/limit sequences, queue scoreboard.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, flush;
  logic [31:0] if_pc, if_instr;
  logic        id_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_wr_reg_n;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_kill;
  logic [4:0]  ex_kill_rd;

  localparam logic [31:0] WBD = 32'hBEEF_0001;

  id_issue_stage_if iss ();

  id_issue_stage #(.PEND_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_ready    (id_ready),
    .flush       (flush),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .iss         (iss),
    .wb_wr_reg_n (wb_wr_reg_n),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_kill     (ex_kill),
    .ex_kill_rd  (ex_kill_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return 32'hC0DE_0000 | {27'd0, a};
  endfunction

  assign rs1_data = rf_val(rs1_addr);
  assign rs2_data = rf_val(rs2_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          chk_imm;
    logic        wr_n;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every issued bundle is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && iss.issue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got pc %h expected no issue", iss.pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pc", iss.pc, mon_e.v.pc);
        chk("pc4", iss.pc4, mon_e.v.pc + 32'd4);
        chk("opcode", {25'd0, iss.opcode}, {25'd0, mon_e.v.opcode});
        chk("rd", {27'd0, iss.rd}, {27'd0, mon_e.v.rd});
        chk("funct3", {29'd0, iss.funct3}, {29'd0, mon_e.v.f3});
        chk("funct7", {25'd0, iss.funct7}, {25'd0, mon_e.v.f7});
        chk("wr_reg_n", {31'd0, iss.wr_reg_n}, {31'd0, mon_e.v.wr_n});
        chk("illegal", {31'd0, iss.illegal}, {31'd0, mon_e.v.ill});
        chk("data1", iss.data1, mon_e.d1);
        chk("data2", iss.data2, mon_e.d2);
        if (mon_e.v.chk_imm) chk("imm", iss.imm, mon_e.v.imm);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input vec_t v);
    if_valid = 1'b1;
    if_pc    = v.pc;
    if_instr = v.instr;
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    present(v);
    e.v  = v;
    e.d1 = rf_val(v.instr[19:15]);
    e.d2 = rf_val(v.instr[24:20]);
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] r);
    wb_wr_reg_n = 1'b0;
    wb_rd       = r;
    wb_data     = WBD;
    step();
    wb_wr_reg_n = 1'b1;
  endtask

  function automatic vec_t addi(input logic [31:0] pc, input logic [4:0] rd, input logic [11:0] imm);
    vec_t v;
    v = '{pc, {imm, 5'd0, 3'd0, rd, 7'h13}, 7'h13, rd, 3'd0, imm[11:5], {{20{imm[11]}}, imm},
          1'b1, (rd == 5'd0), 1'b0};
    return v;
  endfunction

  initial begin
    vec_t vadd;
    exp_t e;

    tbl[0] = '{32'h100, 32'h0050_0093, 7'h13, 5'd1,  3'd0, 7'h00, 32'h0000_0005, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'h104, 32'hFE00_2E23, 7'h23, 5'd28, 3'd2, 7'h7F, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32'h108, 32'h1234_52B7, 7'h37, 5'd5,  3'd5, 7'h09, 32'h1234_5000, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h10C, 32'hFE00_0CE3, 7'h63, 5'd25, 3'd0, 7'h7F, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{32'h110, 32'h0100_00EF, 7'h6F, 5'd1,  3'd0, 7'h00, 32'h0000_0010, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h114, 32'h0000_1017, 7'h17, 5'd0,  3'd1, 7'h00, 32'h0000_1000, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h118, 32'h0000_017F, 7'h7F, 5'd2,  3'd0, 7'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{32'h11C, 32'h0080_01E7, 7'h67, 5'd3,  3'd0, 7'h00, 32'h0000_0008, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{32'h120, 32'hFFF0_2203, 7'h03, 5'd4,  3'd2, 7'h7F, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{32'h124, 32'h4000_0333, 7'h33, 5'd6,  3'd0, 7'h20, 32'h0000_0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0;
    wb_wr_reg_n = 1'b1; wb_rd = '0; wb_data = '0; ex_kill = 1'b0; ex_kill_rd = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_issue_valid", {31'd0, iss.issue_valid}, 32'd0);
    chk("rst_wr_reg_n", {31'd0, iss.wr_reg_n}, 32'd1);
    chk("rst_illegal", {31'd0, iss.illegal}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();

    // Single instructions: accept, issue next cycle, retire through WB.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      step();
      if_valid = 1'b0;
      @(negedge clk);
      chk("issue_lat", {31'd0, iss.issue_valid}, 32'd1);
      step();
      chk("sb_after_issue", {30'd0, dut.pend_q[tbl[i].rd]}, tbl[i].wr_n ? 32'd0 : 32'd1);
      if (!tbl[i].wr_n) wb(tbl[i].rd);
    end

    // RAW hazard: ADD x2,x1,x1 right behind ADDI x1.
    send(addi(32'h200, 5'd1, 12'd5));
    step();
    vadd = '{32'h204, 32'h0010_8133, 7'h33, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0};
    present(vadd);
    e.v = vadd;
`ifdef ID_WB_BYPASS_EN
    e.d1 = WBD; e.d2 = WBD;
`else
    e.d1 = rf_val(5'd1); e.d2 = rf_val(5'd1);
`endif
    exp_q.push_back(e);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("raw_stall", {31'd0, iss.issue_valid}, 32'd0);
    chk("raw_id_ready", {31'd0, id_ready}, 32'd0);
    chk("raw_pend1", {30'd0, dut.pend_q[1]}, 32'd1);
    step();
    @(negedge clk);
    chk("raw_stall2", {31'd0, iss.issue_valid}, 32'd0);
    step();
    wb_wr_reg_n = 1'b0; wb_rd = 5'd1; wb_data = WBD;
    @(negedge clk);
`ifdef ID_WB_BYPASS_EN
    chk("raw_wb_cycle", {31'd0, iss.issue_valid}, 32'd1);
    step();
    wb_wr_reg_n = 1'b1;
`else
    chk("raw_wb_cycle", {31'd0, iss.issue_valid}, 32'd0);
    step();
    wb_wr_reg_n = 1'b1;
    @(negedge clk);
    chk("raw_after_wb", {31'd0, iss.issue_valid}, 32'd1);
    step();
`endif
    wb(5'd2);

    // Flush while the dependent ADD is stalled; a new instruction arrives the same cycle.
    send(addi(32'h300, 5'd1, 12'd9));
    step();
    vadd.pc = 32'h304;
    present(vadd);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("fl_stall", {31'd0, iss.issue_valid}, 32'd0);
    step();
    flush = 1'b1;
    send(addi(32'h400, 5'd7, 12'd1));
    @(negedge clk);
    chk("fl_no_issue", {31'd0, iss.issue_valid}, 32'd0);
    chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    chk("fl_new_issue", {31'd0, iss.issue_valid}, 32'd1);
    chk("fl_new_rd", {27'd0, iss.rd}, 32'd7);
    step();
    chk("fl_pend2", {30'd0, dut.pend_q[2]}, 32'd0);
    wb(5'd1);
    wb(5'd7);

    // Issue to x3 while EX kills an x3 writer: counter stays put.
    send(addi(32'h500, 5'd3, 12'd1));
    step();
    if_valid = 1'b0;
    ex_kill = 1'b1; ex_kill_rd = 5'd3;
    @(negedge clk);
    chk("kill_issue", {31'd0, iss.issue_valid}, 32'd1);
    step();
    ex_kill = 1'b0;
    chk("kill_pend3", {30'd0, dut.pend_q[3]}, 32'd0);

    // x0 destination/source never creates a hazard.
    send(addi(32'h504, 5'd0, 12'd1));
    step();
    send('{32'h508, 32'h0000_0433, 7'h33, 5'd8, 3'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("x0_first", {31'd0, iss.issue_valid}, 32'd1);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("x0_nostall", {31'd0, iss.issue_valid}, 32'd1);
    step();
    wb(5'd8);

    // Four writers to x5 with no WB: the fourth waits for the counter to drop below max.
    for (int k = 0; k < 4; k++) begin
      send(addi(32'h600 + 32'(4 * k), 5'd5, 12'(k + 1)));
      step();
    end
    if_valid = 1'b0;
    @(negedge clk);
    chk("max_stall", {31'd0, iss.issue_valid}, 32'd0);
    chk("max_id_ready", {31'd0, id_ready}, 32'd0);
    chk("max_pend5", {30'd0, dut.pend_q[5]}, 32'd3);
    step();
    wb_wr_reg_n = 1'b0; wb_rd = 5'd5; wb_data = WBD;
    @(negedge clk);
    chk("max_wb_cycle", {31'd0, iss.issue_valid}, 32'd0);
    step();
    wb_wr_reg_n = 1'b1;
    @(negedge clk);
    chk("max_release", {31'd0, iss.issue_valid}, 32'd1);
    step();
    repeat (3) wb(5'd5);
    chk("max_drained", {30'd0, dut.pend_q[5]}, 32'd0);

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
